// File: rtl/openhw_amoseq_if.sv
// Request, response, ALU and uncached bus signals of the AMO read-modify-write sequencer.
// The slave modport is the sequencer's view; master is the LSU/bus/ALU environment's view.
interface openhw_amoseq_if #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned PA_BITS = 56
);
  logic               ReqValid;
  logic               ReqReady;
  logic [PA_BITS-1:0] ReqPAdr;
  logic [6:0]         ReqFunct7;
  logic [2:0]         ReqFunct3;
  logic [XLEN-1:0]    ReqWriteData;

  logic [XLEN-1:0]    AluReadData;
  logic [XLEN-1:0]    AluWriteData;
  logic [6:0]         AluFunct7;
  logic [2:0]         AluFunct3;
  logic [XLEN-1:0]    AluResult;

  logic               BusReq;
  logic               BusWrite;
  logic [PA_BITS-1:0] BusAdr;
  logic [2:0]         BusSize;
  logic [XLEN-1:0]    BusWData;
  logic               BusLock;
  logic               BusAck;
  logic [XLEN-1:0]    BusRData;
  logic               BusErr;

  logic               RspValid;
  logic [XLEN-1:0]    RspData;
  logic               RspErr;
  logic               RspReady;

  modport slave (
    input  ReqValid, ReqPAdr, ReqFunct7, ReqFunct3, ReqWriteData,
    output ReqReady,
    output AluReadData, AluWriteData, AluFunct7, AluFunct3,
    input  AluResult,
    output BusReq, BusWrite, BusAdr, BusSize, BusWData, BusLock,
    input  BusAck, BusRData, BusErr,
    output RspValid, RspData, RspErr,
    input  RspReady
  );

  modport master (
    output ReqValid, ReqPAdr, ReqFunct7, ReqFunct3, ReqWriteData,
    input  ReqReady,
    input  AluReadData, AluWriteData, AluFunct7, AluFunct3,
    output AluResult,
    input  BusReq, BusWrite, BusAdr, BusSize, BusWData, BusLock,
    output BusAck, BusRData, BusErr,
    input  RspValid, RspData, RspErr,
    output RspReady
  );
endinterface

// File: rtl/openhw_amoseq.sv
// Locked read / ALU / locked write sequencer for AMOs to uncached or device memory.
// All outputs are decoded from state or registered; no Bus* input reaches a Bus* output.
module openhw_amoseq #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned PA_BITS = 56,
  parameter int unsigned TIMEOUT = 255
) (
  input logic             clk,
  input logic             reset_n,
  openhw_amoseq_if.slave  io
);

  typedef enum logic [2:0] {StIdle, StRead, StCalc, StWrite, StResp} state_e;

  // Timeout fires on the cycle that would bring the count to TIMEOUT.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [PA_BITS-1:0] adr_q, adr_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [6:0]         funct7_q, funct7_d;
  logic [XLEN-1:0]    opnd_q, opnd_d;
  logic [XLEN-1:0]    old_q, old_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic               err_q, err_d;
  logic [7:0]         cnt_q, cnt_d;

  logic               is_word;
  logic               req_legal;
  logic               req_aligned;
  logic [XLEN-1:0]    rdata_ext;
  logic [XLEN-1:0]    wdata_bus;

  assign is_word     = (funct3_q == 3'b010);
  assign req_legal   = (io.ReqFunct3 == 3'b010) || ((io.ReqFunct3 == 3'b011) && (XLEN == 64));
  assign req_aligned = (io.ReqFunct3 == 3'b010) ? (io.ReqPAdr[1:0] == 2'b00)
                                                 : (io.ReqPAdr[2:0] == 3'b000);

  if (XLEN == 64) begin : g_lane64
    logic [31:0] lane_word;
    assign lane_word = adr_q[2] ? io.BusRData[63:32] : io.BusRData[31:0];
    assign rdata_ext = is_word ? {{32{lane_word[31]}}, lane_word} : io.BusRData;
    assign wdata_bus = is_word ? {2{result_q[31:0]}} : result_q;
  end else begin : g_lane32
    assign rdata_ext = io.BusRData;
    assign wdata_bus = result_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      adr_q    <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      opnd_q   <= '0;
      old_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      funct3_q <= funct3_d;
      funct7_q <= funct7_d;
      opnd_q   <= opnd_d;
      old_q    <= old_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    funct3_d = funct3_q;
    funct7_d = funct7_q;
    opnd_d   = opnd_q;
    old_d    = old_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (io.ReqValid) begin
          adr_d    = io.ReqPAdr;
          funct3_d = io.ReqFunct3;
          funct7_d = io.ReqFunct7;
          opnd_d   = io.ReqWriteData;
          old_d    = '0;
          result_d = '0;
          cnt_d    = '0;
          if (!req_legal || !req_aligned) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            err_d   = 1'b0;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (io.BusAck) begin
          if (io.BusErr) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            old_d   = rdata_ext;
            state_d = StCalc;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TimeoutLast) begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StCalc: begin
        result_d = io.AluResult;
        cnt_d    = '0;
        state_d  = StWrite;
      end
      StWrite: begin
        if (io.BusAck) begin
          err_d   = io.BusErr;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TimeoutLast) begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (io.RspReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  logic in_read, in_calc, in_write, in_resp, busy;
  assign in_read  = (state_q == StRead);
  assign in_calc  = (state_q == StCalc);
  assign in_write = (state_q == StWrite);
  assign in_resp  = (state_q == StResp);
  assign busy     = (state_q != StIdle);

  assign io.ReqReady     = (state_q == StIdle);
  assign io.AluReadData  = busy ? old_q : '0;
  assign io.AluWriteData = busy ? opnd_q : '0;
  assign io.AluFunct7    = busy ? funct7_q : '0;
  assign io.AluFunct3    = busy ? funct3_q : '0;

  assign io.BusReq   = in_read | in_write;
  assign io.BusWrite = in_write;
  assign io.BusLock  = in_read | in_calc | in_write;
  assign io.BusAdr   = (in_read | in_write) ? adr_q : '0;
  assign io.BusSize  = (in_read | in_write) ? funct3_q : '0;
  assign io.BusWData = in_write ? wdata_bus : '0;

  assign io.RspValid = in_resp;
  assign io.RspData  = in_resp ? old_q : '0;
  assign io.RspErr   = in_resp & err_q;

endmodule

// File: tb/tb_openhw_amoseq.sv
// Bench for openhw_amoseq: bus/memory responder, ALU stand-in, AMO reference model and a
// scoreboard monitor, followed by directed timing cases and a randomized run.
module tb_openhw_amoseq;
  localparam int unsigned XLEN    = 64;
  localparam int unsigned PA_BITS = 56;
  localparam int unsigned TIMEOUT = 8;
  localparam logic [55:0] BASE    = 56'h1000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  openhw_amoseq_if #(.XLEN(XLEN), .PA_BITS(PA_BITS)) bus_if ();

  openhw_amoseq #(.XLEN(XLEN), .PA_BITS(PA_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (bus_if)
  );

  int total = 0;
  int bad   = 0;
  // 0 ok, 1 read fault, 2 write fault, 3 read never acked, 4 write never acked
  int cur_mode = 0;
  int max_wait = 0;
  int rdy_pct  = 100;
  bit rdy_hold = 1'b0;

  logic [63:0] bus_mem [16];
  logic [63:0] ref_mem [16];
  logic [63:0] exp_d_q [$];
  logic        exp_e_q [$];

  function automatic logic [63:0] init_val(int i);
    logic [63:0] v;
    v = 64'h5A5A_0F0F_3C3C_9669 ^ (64'(i) * 64'h9E37_79B9_7F4A_7C15);
    if (i == 0) v = 64'h10;
    return v;
  endfunction

  function automatic logic [63:0] amo_op(logic [4:0] f5, logic [63:0] a, logic [63:0] b);
    case (f5)
      5'b00000: return a + b;
      5'b00001: return b;
      5'b00100: return a ^ b;
      5'b01000: return a | b;
      5'b01100: return a & b;
      default:  return 64'h0;
    endcase
  endfunction

  assign bus_if.AluResult = amo_op(bus_if.AluFunct7[6:2], bus_if.AluReadData,
                                   bus_if.AluWriteData);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: AMO semantics on the bench's own copy of memory.
  task automatic model(input logic [55:0] adr, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] rs2, input int md,
                       output logic [63:0] d, output logic e);
    int          idx;
    logic [63:0] m, nm;
    logic [31:0] o32, n32;
    bit          word, legal, misal;
    word  = (f3 == 3'b010);
    legal = word || (f3 == 3'b011);
    misal = word ? (adr[1:0] != 2'b00) : (adr[2:0] != 3'b000);
    idx   = int'(adr[6:3]);
    d = 64'h0;
    e = 1'b1;
    if (!legal || misal) return;
    m  = ref_mem[idx];
    nm = m;
    if (word) begin
      o32 = adr[2] ? m[63:32] : m[31:0];
      d   = {{32{o32[31]}}, o32};
      n32 = 32'(amo_op(f7[6:2], {32'h0, o32}, {32'h0, rs2[31:0]}));
      if (adr[2]) nm[63:32] = n32;
      else        nm[31:0]  = n32;
    end else begin
      d  = m;
      nm = amo_op(f7[6:2], m, rs2);
    end
    case (md)
      0:       begin e = 1'b0; ref_mem[idx] = nm; end
      1, 3:    begin d = 64'h0; e = 1'b1; end
      default: e = 1'b1;
    endcase
  endtask

  // Drives one request; on acceptance returns #1 after the accept edge.
  task automatic issue(input logic [55:0] adr, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] rs2, input int md);
    logic [63:0] d;
    logic        e;
    bit          acc;
    bus_if.ReqValid     = 1'b1;
    bus_if.ReqPAdr      = adr;
    bus_if.ReqFunct3    = f3;
    bus_if.ReqFunct7    = f7;
    bus_if.ReqWriteData = rs2;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (bus_if.ReqReady) begin
        acc      = 1'b1;
        cur_mode = md;
      end
      @(posedge clk);
    end
    #1;
    bus_if.ReqValid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL req_accept: ReqReady never seen for adr %h", adr);
    end else begin
      model(adr, f3, f7, rs2, md, d, e);
      exp_d_q.push_back(d);
      exp_e_q.push_back(e);
    end
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_d_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_d_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_d_q.size());
    end
  endtask

  // Bus responder with random wait states and per-transaction fault injection.
  initial begin
    int waited, wtarget, i;
    bit stall;
    for (int k = 0; k < 16; k++) bus_mem[k] = init_val(k);
    bus_if.BusAck = 1'b0; bus_if.BusErr = 1'b0; bus_if.BusRData = '0;
    waited = 0;
    wtarget = 0;
    forever begin
      @(posedge clk);
      #1;
      bus_if.BusAck = 1'b0; bus_if.BusErr = 1'b0; bus_if.BusRData = '0;
      if (!bus_if.BusReq) begin
        waited  = 0;
        wtarget = int'($urandom_range(0, max_wait));
      end else begin
        stall = (!bus_if.BusWrite && cur_mode == 3) || (bus_if.BusWrite && cur_mode == 4);
        if (!stall && waited >= wtarget) begin
          bus_if.BusAck = 1'b1;
          i = int'(bus_if.BusAdr[6:3]);
          if (!bus_if.BusWrite) begin
            bus_if.BusErr   = (cur_mode == 1);
            bus_if.BusRData = bus_mem[i];
          end else begin
            bus_if.BusErr = (cur_mode == 2);
            if (cur_mode != 2) begin
              if (bus_if.BusSize == 3'b010) begin
                if (bus_if.BusAdr[2]) bus_mem[i][63:32] = bus_if.BusWData[63:32];
                else                  bus_mem[i][31:0]  = bus_if.BusWData[31:0];
              end else begin
                bus_mem[i] = bus_if.BusWData;
              end
            end
          end
        end else begin
          waited++;
        end
      end
    end
  end

  initial begin
    bus_if.RspReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_if.RspReady = !rdy_hold && (int'($urandom_range(0, 99)) < rdy_pct);
    end
  end

  // Scoreboard monitor: compare every handshaked response against the model's queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && bus_if.RspValid && bus_if.RspReady) begin
        if (exp_d_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got data %h, expected no response", bus_if.RspData);
        end else begin
          chk("rsp_data", bus_if.RspData, exp_d_q.pop_front());
          chk("rsp_err", 64'(bus_if.RspErr), 64'(exp_e_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [63:0] old;
    logic [55:0] adr;
    logic [2:0]  f3, t3;
    logic [6:0]  f7;
    logic [4:0]  f5;
    int          n, k;
    bus_if.ReqValid = 1'b0; bus_if.ReqPAdr = '0; bus_if.ReqFunct3 = '0;
    bus_if.ReqFunct7 = '0; bus_if.ReqWriteData = '0;
    for (int j = 0; j < 16; j++) ref_mem[j] = init_val(j);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus_if.ReqReady), 64'd1);
    chk("rst_bus_req", 64'(bus_if.BusReq), 64'd0);
    chk("rst_bus_lock", 64'(bus_if.BusLock), 64'd0);
    chk("rst_rsp_valid", 64'(bus_if.RspValid), 64'd0);
    chk("rst_rsp_data", bus_if.RspData, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // AMOADD.D, zero-wait bus
    issue(BASE, 3'b011, 7'b0000000, 64'd5, 0);
    chk("t1_read_req", 64'({bus_if.BusReq, bus_if.BusWrite, bus_if.BusLock}), 64'b101);
    chk("t1_read_adr", 64'(bus_if.BusAdr), 64'h1000);
    @(posedge clk); #1;
    chk("t1_calc", 64'({bus_if.BusReq, bus_if.BusLock}), 64'b01);
    @(posedge clk); #1;
    chk("t1_write", 64'({bus_if.BusReq, bus_if.BusWrite, bus_if.BusLock}), 64'b111);
    chk("t1_wdata", bus_if.BusWData, 64'h15);
    @(posedge clk); #1;
    chk("t1_rsp", 64'({bus_if.RspValid, bus_if.BusLock}), 64'b10);
    chk("t1_rsp_data", bus_if.RspData, 64'h10);
    drain(50);

    // AMOSWAP.D sets up the doubleword, then AMOSWAP.W on the upper lane
    issue(BASE, 3'b011, 7'b0000100, 64'hFFFF_FFFF_0000_0001, 0);
    drain(50);
    issue(BASE + 56'h4, 3'b010, 7'b0000100, 64'h7, 0);
    @(posedge clk); #1;
    chk("t2_alu_read", bus_if.AluReadData, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    chk("t2_wdata", bus_if.BusWData, 64'h0000_0007_0000_0007);
    @(posedge clk); #1;
    chk("t2_rsp_data", bus_if.RspData, 64'hFFFF_FFFF_FFFF_FFFF);
    drain(50);

    // Read fault
    issue(BASE + 56'h8, 3'b011, 7'b0000000, 64'h1, 1);
    @(posedge clk); #1;
    chk("t3_no_write", 64'(bus_if.BusReq), 64'd0);
    chk("t3_rsp", 64'({bus_if.RspValid, bus_if.RspErr}), 64'b11);
    chk("t3_rsp_data", bus_if.RspData, 64'd0);
    drain(50);

    // Read timeout
    issue(BASE + 56'h10, 3'b011, 7'b0000000, 64'h1, 3);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus_if.BusReq) break;
      n++;
      @(posedge clk); #1;
    end
    chk("t4_read_cycles", 64'(n), 64'(TIMEOUT));
    chk("t4_rsp", 64'({bus_if.RspValid, bus_if.RspErr, bus_if.BusLock}), 64'b110);
    drain(50);

    // Misaligned AMOOR.W
    issue(BASE + 56'h2, 3'b010, 7'b0100000, 64'h3, 0);
    chk("t5_misaligned", 64'({bus_if.BusReq, bus_if.RspValid, bus_if.RspErr}), 64'b011);
    drain(50);

    // Backpressure: response must hold while RspReady is low
    rdy_hold = 1'b1;
    old = ref_mem[3];
    issue(BASE + 56'h18, 3'b011, 7'b0000000, 64'h1, 0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t6_hold_valid", 64'(bus_if.RspValid), 64'd1);
      chk("t6_hold_data", bus_if.RspData, old);
      @(posedge clk); #1;
    end
    rdy_hold = 1'b0;
    drain(50);

    // Reset during WRITE
    issue(BASE + 56'h20, 3'b011, 7'b0000000, 64'h2, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t7_in_write", 64'(bus_if.BusWrite), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t7_rst_async", 64'({bus_if.BusReq, bus_if.BusLock, bus_if.RspValid}), 64'b000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_d_q.delete();
    exp_e_q.delete();
    @(posedge clk); #1;
    chk("t7_req_ready", 64'(bus_if.ReqReady), 64'd1);

    // Randomized traffic
    max_wait = 3;
    rdy_pct  = 70;
    for (int t = 0; t < 150; t++) begin
      k = int'($urandom_range(0, 4));
      f5 = (k == 0) ? 5'b00000 : (k == 1) ? 5'b00001 : (k == 2) ? 5'b00100 :
           (k == 3) ? 5'b01000 : 5'b01100;
      f7 = {f5, 2'($urandom_range(0, 3))};
      k = int'($urandom_range(0, 99));
      t3 = 3'($urandom_range(0, 5));
      f3 = (k < 45) ? 3'b010 : (k < 90) ? 3'b011 : ((t3 < 3'd2) ? t3 : t3 + 3'd2);
      adr = BASE + 56'($urandom_range(0, 15) * 8);
      if ($urandom_range(0, 9) == 0) adr = adr + 56'($urandom_range(1, 7));
      else if (f3 == 3'b010 && $urandom_range(0, 1) == 1) adr = adr + 56'h4;
      issue(adr, f3, f7, {$urandom, $urandom},
            ($urandom_range(0, 99) < 60) ? 0 : int'($urandom_range(1, 4)));
    end
    drain(3000);
    for (int j = 0; j < 16; j++) chk($sformatf("mem[%0d]", j), bus_mem[j], ref_mem[j]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
